// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit MIPS datapath: widths, opcodes, fetch FSM.
package mips_pkg;

  localparam int INSTR_W = 16;

  // Decoded opcode set; the control decoder uses the same constants.
  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_BNE = 4'd14;

  // Bubble encoding: decodes as AND, so consumers must qualify with valid.
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } if_state_e;

endpackage

// File: rtl/opcode_legal_chk.sv
// Flags whether a 4-bit opcode belongs to the decoded instruction set.
module opcode_legal_chk (
  input  logic [3:0] op,
  output logic       legal
);
  import mips_pkg::*;

  // Membership test against the shared opcode constants.
  always_comb begin
    legal = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB,
      OP_SLT, OP_LW, OP_SW, OP_BNE: legal = 1'b1;
      default:                      legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, IF/ID register, BOOT/RUN/HALT control.
module if_stage #(
  parameter int                 INSTR_W  = 16,
  parameter logic [INSTR_W-1:0] RESET_PC = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [INSTR_W-1:0] branch_target,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [INSTR_W-1:0] if_id_pc1,
  output logic               if_id_valid,
  output logic [3:0]         opcode,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_cnt
);
  import mips_pkg::*;

  localparam logic [INSTR_W-1:0] BUBBLE = INSTR_W'(NOP_INSTR);

  if_state_e          state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] pc1_q, pc1_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [INSTR_W-1:0] pc_inc;
  logic               op_legal;
  logic               illegal_hit;

  assign pc_inc      = pc_q + INSTR_W'(1);
  assign opcode      = instr_q[INSTR_W-1 -: 4];
  assign illegal_hit = valid_q && !op_legal;

  opcode_legal_chk u_legal (
    .op    (opcode),
    .legal (op_legal)
  );

  // Next-state, PC and IF/ID update; everything holds unless a case below moves it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: begin
        // One address-setup cycle; IF/ID is already a bubble from reset.
        state_d = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          // Redirect wins over stall and also squashes an illegal op in IF/ID.
          pc_d    = branch_target;
          instr_d = BUBBLE;
          pc1_d   = '0;
          valid_d = 1'b0;
        end else if (illegal_hit) begin
          // Halt even under stall; PC freezes at its current value.
          state_d = HALT;
          instr_d = BUBBLE;
          pc1_d   = '0;
          valid_d = 1'b0;
        end else if (!stall) begin
          pc_d    = pc_inc;
          instr_d = imem_rdata;
          pc1_d   = pc_inc;
          valid_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HALT: begin
        // Sticky until reset; keep IF/ID a bubble.
        instr_d = BUBBLE;
        pc1_d   = '0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = HALT;
        instr_d = BUBBLE;
        pc1_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= BUBBLE;
      pc1_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc1   = pc1_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == HALT);
  assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch order, stall, branch, halt, wrap, saturation, reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] imem_addr, imem_rdata;
  logic [15:0] if_id_instr, if_id_pc1;
  logic        if_id_valid, halted;
  logic [3:0]  opcode;
  logic [15:0] fetch_cnt;

  // Second instance with a narrow counter to reach saturation quickly.
  logic [15:0] s_addr, s_instr, s_pc1;
  logic        s_valid, s_halted;
  logic [3:0]  s_opcode;
  logic [2:0]  s_cnt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [15:0] a);
    case (a)
      16'h0000: rom = 16'h2011;
      16'h0001: rom = 16'h0022;
      16'h0002: rom = 16'h6033;
      16'h0003: rom = 16'h7044;
      16'h0004: rom = 16'h8055;
      16'h0005: rom = 16'h3000;
      16'h0040: rom = 16'h1abc;
      16'h0041: rom = 16'h3111;
      16'hFFFF: rom = 16'h2fff;
      default:  rom = {4'h2, a[11:0]};
    endcase
  endfunction

  assign imem_rdata = rom(imem_addr);

  if_stage #(.INSTR_W(16), .RESET_PC(16'h0000), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc1(if_id_pc1), .if_id_valid(if_id_valid),
    .opcode(opcode), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  if_stage #(.INSTR_W(16), .RESET_PC(16'h0000), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(16'h0000), .imem_addr(s_addr), .imem_rdata(16'h2000),
    .if_id_instr(s_instr), .if_id_pc1(s_pc1), .if_id_valid(s_valid),
    .opcode(s_opcode), .halted(s_halted), .fetch_cnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, sampled with no clock edge involved.
    #3;
    chk("rst_pc", imem_addr, 16'h0000);
    chk("rst_instr", if_id_instr, 16'h0000);
    chk("rst_pc1", if_id_pc1, 16'h0000);
    chk("rst_valid", if_id_valid, 1'b0);
    chk("rst_halt", halted, 1'b0);
    chk("rst_cnt", fetch_cnt, 16'h0000);
    #9 rst_n = 1'b1;

    // Edge 1: BOOT, nothing captured.
    tick();
    chk("boot_pc", imem_addr, 16'h0000);
    chk("boot_valid", if_id_valid, 1'b0);
    // Edges 2..5: ROM[0..3].
    tick();
    chk("f0_op", opcode, 4'h2);   chk("f0_pc1", if_id_pc1, 16'h0001);
    chk("f0_valid", if_id_valid, 1'b1); chk("f0_cnt", fetch_cnt, 16'd1);
    tick();
    chk("f1_op", opcode, 4'h0);   chk("f1_pc1", if_id_pc1, 16'h0002);
    tick();
    chk("f2_op", opcode, 4'h6);   chk("f2_pc1", if_id_pc1, 16'h0003);
    tick();
    chk("f3_op", opcode, 4'h7);   chk("f3_pc1", if_id_pc1, 16'h0004);
    chk("f3_cnt", fetch_cnt, 16'd4); chk("f3_pc", imem_addr, 16'h0004);
    chk("sat_cnt4", s_cnt, 3'd4);
    // Edge 6: LW captured; ROM[5] (illegal) sits at the ROM output.
    tick();
    chk("lw_instr", if_id_instr, 16'h8055);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stl_pc", imem_addr, 16'h0005);
      chk("stl_instr", if_id_instr, 16'h8055);
      chk("stl_pc1", if_id_pc1, 16'h0005);
      chk("stl_cnt", fetch_cnt, 16'd5);
    end
    // Branch with stall also high: redirect wins.
    branch_taken = 1'b1; branch_target = 16'h0040;
    tick();
    chk("br_pc", imem_addr, 16'h0040);
    chk("br_valid", if_id_valid, 1'b0);
    chk("br_cnt", fetch_cnt, 16'd5);
    chk("sat_cnt7", s_cnt, 3'd7);
    stall = 1'b0; branch_taken = 1'b0;
    tick();
    chk("tgt_instr", if_id_instr, 16'h1abc);
    chk("tgt_pc1", if_id_pc1, 16'h0041);
    chk("tgt_valid", if_id_valid, 1'b1);
    // Illegal op 3 captured, then flushed by a branch on the next edge.
    tick();
    chk("ill_op", opcode, 4'h3);
    chk("sat_hold", s_cnt, 3'd7);
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    tick();
    chk("fl_halt", halted, 1'b0);
    chk("fl_pc", imem_addr, 16'hFFFF);
    chk("fl_valid", if_id_valid, 1'b0);
    // PC wrap from FFFF.
    branch_taken = 1'b0;
    tick();
    chk("wr_pc", imem_addr, 16'h0000);
    chk("wr_pc1", if_id_pc1, 16'h0000);
    chk("wr_instr", if_id_instr, 16'h2fff);
    chk("wr_cnt", fetch_cnt, 16'd8);
    // Go fetch ROM[5] = 16'h3000 and let it halt the stage.
    branch_taken = 1'b1; branch_target = 16'h0005;
    tick();
    branch_taken = 1'b0;
    tick();
    chk("h_op", opcode, 4'h3);
    chk("h_pc", imem_addr, 16'h0006);
    stall = 1'b1;
    tick();
    chk("h_halted", halted, 1'b1);
    chk("h_valid", if_id_valid, 1'b0);
    chk("h_opbub", opcode, 4'h0);
    chk("h_pcfz", imem_addr, 16'h0006);
    stall = 1'b0; branch_taken = 1'b1; branch_target = 16'h0040;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hz_pc", imem_addr, 16'h0006);
      chk("hz_halted", halted, 1'b1);
      chk("hz_valid", if_id_valid, 1'b0);
      chk("hz_cnt", fetch_cnt, 16'd9);
      stall = 1'b1; branch_taken = 1'b0;
    end
    // Asynchronous reset mid-run, no clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("ar_halt", halted, 1'b0);
    chk("ar_pc", imem_addr, 16'h0000);
    chk("ar_cnt", fetch_cnt, 16'h0000);
    chk("ar_instr", if_id_instr, 16'h0000);
    chk("ar_scnt", s_cnt, 3'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
